keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 177 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: one-hot column strobes, synchronized row readback,
// full-scan classification and a press/release debounce FSM.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SETTLE_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [3:0]    row_meta_q, row_s_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    col_q, col_d;
  logic [11:0]   scan_buf_q, scan_buf_d;
  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic          sample, scan_end;
  logic [15:0]   full_scan;
  logic [4:0]    ones;
  logic [3:0]    hit_code;
  logic          res_none, res_single, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q  <= '0;
      row_s_q     <= '0;
      dwell_q     <= '0;
      col_q       <= 4'b0001;
      scan_buf_q  <= '0;
      state_q     <= S_IDLE;
      count_q     <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row_in;
      row_s_q     <= row_meta_q;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      scan_buf_q  <= scan_buf_d;
      state_q     <= state_d;
      count_q     <= count_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Column dwell and per-column capture of the synchronized rows
  always_comb begin
    dwell_d    = dwell_q + DW'(1);
    col_d      = col_q;
    scan_buf_d = scan_buf_q;
    sample     = (dwell_q == DWELL_LAST);
    scan_end   = sample && col_q[3];
    if (sample) begin
      dwell_d = '0;
      col_d   = {col_q[2:0], col_q[3]};
      case (col_q)
        4'b0001: scan_buf_d[3:0]  = row_s_q;
        4'b0010: scan_buf_d[7:4]  = row_s_q;
        4'b0100: scan_buf_d[11:8] = row_s_q;
        default: ;
      endcase
    end
  end

  // Bit index col*4+row of the assembled scan is exactly the key code
  always_comb begin
    full_scan = {row_s_q, scan_buf_q};
    ones      = '0;
    hit_code  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (full_scan[i]) begin
        ones     = ones + 5'd1;
        hit_code = 4'(i);
      end
    end
    res_none   = (ones == 5'd0);
    res_single = (ones == 5'd1);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    if (scan_end) begin
      case (state_q)
        S_IDLE: begin
          if (res_single) begin
            cand_d  = hit_code;
            count_d = CNT_ONE;
            if (CNT_ONE >= CNT_TARGET) accept = 1'b1;
            else                       state_d = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (res_single && (hit_code == cand_q)) begin
            if (count_q + CNT_ONE >= CNT_TARGET) accept = 1'b1;
            else                                 count_d = count_q + CNT_ONE;
          end else begin
            state_d = S_IDLE;
            count_d = '0;
          end
        end
        S_PRESSED: begin
          if (res_none) begin
            if (CNT_ONE >= CNT_TARGET) begin
              state_d    = S_IDLE;
              count_d    = '0;
              key_held_d = 1'b0;
            end else begin
              state_d = S_RELEASE;
              count_d = CNT_ONE;
            end
          end
        end
        S_RELEASE: begin
          if (res_none) begin
            if (count_q + CNT_ONE >= CNT_TARGET) begin
              state_d    = S_IDLE;
              count_d    = '0;
              key_held_d = 1'b0;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end else begin
            state_d = S_PRESSED;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (accept) begin
        key_code_d  = cand_d;
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
        state_d     = S_PRESSED;
        count_d     = '0;
      end
    end
  end

  assign col_out   = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives row_in from col_out;
// expected presses are queued by the stimulus and matched by a pulse monitor.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys_down = '0;
  int unsigned rcyc;
  int          tests = 0;
  int          fails = 0;
  logic        prev_valid = 1'b0;

  typedef struct {
    logic [3:0]  code;
    int unsigned lo;
    int unsigned hi;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [15:0] K0  = 16'h0001;
  localparam logic [15:0] K5  = 16'h0020;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K15 = 16'h8000;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SETTLE_CYCLES (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Pull-down matrix: a pressed key connects its column strobe to its row
  always_comb begin
    row_in = '0;
    for (int c = 0; c < 4; c++)
      if (col_out[c]) row_in = row_in | keys_down[c*4 +: 4];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) rcyc <= 0;
    else     rcyc <= rcyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse monitor and scan-sequence model
  always @(negedge clk) begin
    logic [3:0] exp_col;
    exp_t       e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      exp_col = 4'b0001 << ((rcyc / 4) % 4);
      chk("col_out", {28'd0, col_out}, {28'd0, exp_col});
      if (key_valid) begin
        chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: key_valid with code %0h at cycle %0d, none expected", key_code, rcyc);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_code", {28'd0, key_code}, {28'd0, e.code});
          chk("pulse_held", {31'd0, key_held}, 32'd1);
          tests++;
          if (rcyc < e.lo || rcyc > e.hi) begin
            fails++;
            $display("FAIL pulse_time: got cycle %0d expected %0d..%0d", rcyc, e.lo, e.hi);
          end
        end
      end
      prev_valid = key_valid;
    end
  end

  task automatic align();
    @(negedge clk);
    while (rcyc % 16 != 0) @(negedge clk);
  endtask

  task automatic scans(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [3:0] code, input int unsigned lo, input int unsigned hi);
    exp_t e;
    e.code = code;
    e.lo   = lo;
    e.hi   = hi;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 64 && sb_q.size() != 0; i++) @(negedge clk);
    chk(name, sb_q.size(), 0);
  endtask

  initial begin
    int unsigned s;
    // 1: reset state and idle scanning
    repeat (2) @(negedge clk);
    chk("rst_col", {28'd0, col_out}, 32'h1);
    chk("rst_code", {28'd0, key_code}, 32'h0);
    chk("rst_valid", {31'd0, key_valid}, 32'h0);
    chk("rst_held", {31'd0, key_held}, 32'h0);
    rst = 1'b0;
    repeat (64) @(negedge clk);
    chk("idle_held", {31'd0, key_held}, 32'h0);
    chk("idle_code", {28'd0, key_code}, 32'h0);

    // 2: clean press of key 9, accepted on the third scan end
    align();
    s = rcyc;
    keys_down = K9;
    expect_pulse(4'h9, s + 47, s + 49);
    scans(8);
    drain("t2_missing_pulse");
    chk("t2_code", {28'd0, key_code}, 32'h9);
    chk("t2_held", {31'd0, key_held}, 32'h1);
    keys_down = '0;
    repeat (47) @(negedge clk);
    chk("t2_held_before_release", {31'd0, key_held}, 32'h1);
    repeat (2) @(negedge clk);
    chk("t2_released", {31'd0, key_held}, 32'h0);
    chk("t2_code_kept", {28'd0, key_code}, 32'h9);

    // 3: bouncing press and bouncing release
    align();
    s = rcyc;
    expect_pulse(4'h9, s + 48, s + 80);
    for (int i = 0; i < 8; i++) begin
      keys_down = (i % 2 == 0) ? K9 : '0;
      repeat (5) @(negedge clk);
    end
    keys_down = K9;
    repeat (88) @(negedge clk);
    drain("t3_missing_pulse");
    chk("t3_code", {28'd0, key_code}, 32'h9);
    align();
    s = rcyc;
    for (int i = 0; i < 8; i++) begin
      keys_down = (i % 2 == 0) ? '0 : K9;
      repeat (5) @(negedge clk);
    end
    keys_down = '0;
    chk("t3_held_during_bounce", {31'd0, key_held}, 32'h1);
    repeat (44) @(negedge clk);
    chk("t3_released", {31'd0, key_held}, 32'h0);

    // 4: two keys are ambiguous; dropping one leaves a single key 15
    align();
    keys_down = K0 | K15;
    scans(10);
    chk("t4_multi_held", {31'd0, key_held}, 32'h0);
    chk("t4_multi_code", {28'd0, key_code}, 32'h9);
    align();
    s = rcyc;
    keys_down = K15;
    expect_pulse(4'hF, s + 47, s + 49);
    scans(4);
    drain("t4_missing_pulse");
    chk("t4_code", {28'd0, key_code}, 32'hF);
    keys_down = '0;
    scans(4);
    chk("t4_released", {31'd0, key_held}, 32'h0);

    // 5: second key while held is ignored until a full release
    align();
    s = rcyc;
    keys_down = K9;
    expect_pulse(4'h9, s + 47, s + 49);
    scans(4);
    keys_down = K9 | K5;
    scans(10);
    drain("t5_missing_first");
    chk("t5_code_kept", {28'd0, key_code}, 32'h9);
    chk("t5_held", {31'd0, key_held}, 32'h1);
    keys_down = '0;
    scans(4);
    chk("t5_released", {31'd0, key_held}, 32'h0);
    align();
    s = rcyc;
    keys_down = K5;
    expect_pulse(4'h5, s + 47, s + 49);
    scans(4);
    drain("t5_missing_second");
    chk("t5_code", {28'd0, key_code}, 32'h5);
    keys_down = '0;
    scans(4);

    // 6: asynchronous reset while a key is held, then re-acceptance
    align();
    s = rcyc;
    keys_down = K9;
    expect_pulse(4'h9, s + 47, s + 49);
    scans(4);
    drain("t6_missing_first");
    chk("t6_held_before_rst", {31'd0, key_held}, 32'h1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_col", {28'd0, col_out}, 32'h1);
    chk("t6_rst_held", {31'd0, key_held}, 32'h0);
    chk("t6_rst_valid", {31'd0, key_valid}, 32'h0);
    chk("t6_rst_code", {28'd0, key_code}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_pulse(4'h9, 47, 49);
    scans(4);
    drain("t6_missing_repress");
    chk("t6_code", {28'd0, key_code}, 32'h9);
    chk("t6_held", {31'd0, key_held}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: bench did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
